// File: rtl/caliptra_fpga_sync_sched_if.sv
// Command/event handshake bundle for the sync-counter event scheduler.
// The scheduler is the slave; whoever queues commands and consumes events is the master.
interface caliptra_fpga_sync_sched_if #(
  parameter int ID_W = 8
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic [63:0]     cmd_time;
  logic [ID_W-1:0] cmd_id;
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic [63:0]     evt_time;
  logic            evt_late;

  modport master (
    output cmd_valid, cmd_time, cmd_id, evt_ready,
    input  cmd_ready, evt_valid, evt_id, evt_time, evt_late
  );

  modport slave (
    input  cmd_valid, cmd_time, cmd_id, evt_ready,
    output cmd_ready, evt_valid, evt_id, evt_time, evt_late
  );
endinterface

// File: rtl/caliptra_fpga_sync_sched.sv
// Timed-event scheduler: FIFO of (time, id) commands released on a valid/ready
// port once the free-running sync counter reaches the head entry's time.
module caliptra_fpga_sync_sched #(
  parameter  int DEPTH    = 8,
  parameter  int ID_W     = 8,
  parameter  int LATE_TOL = 0,
  localparam int PW       = $clog2(DEPTH+1)
) (
  input  logic                   aclk,
  input  logic                   rstn,
  input  logic [63:0]            counter,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   err_clr,
  caliptra_fpga_sync_sched_if.slave bus,
  output logic [PW-1:0]          pending,
  output logic                   order_err,
  output logic [15:0]            late_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_e;

  typedef struct packed {
    logic [63:0]     t;
    logic [ID_W-1:0] id;
  } ent_t;

  ent_t            mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [PW-1:0]   cnt_q;
  logic [63:0]     last_q;
  state_e          state_q;
  logic            evt_valid_q, evt_late_q, order_err_q;
  logic [ID_W-1:0] evt_id_q;
  logic [63:0]     evt_time_q;
  logic [15:0]     late_cnt_q;

  ent_t        head;
  logic        rdy, push, fire, late;
  logic [63:0] lag;

  assign head = mem_q[rptr_q];
  // No bypass: a full queue refuses even when the head pops this cycle.
  assign rdy  = (cnt_q < PW'(DEPTH)) & ~flush;
  assign push = bus.cmd_valid & rdy;
  assign fire = (state_q == ARMED) & enable & ~flush & (cnt_q != '0) & (counter >= head.t);
  assign lag  = counter - head.t;
  assign late = lag > 64'(LATE_TOL);

  always_ff @(posedge aclk) begin
    if (push) mem_q[wptr_q] <= '{t: bus.cmd_time, id: bus.cmd_id};
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_time_q  <= '0;
      evt_late_q  <= 1'b0;
      order_err_q <= 1'b0;
      late_cnt_q  <= '0;
    end else begin
      // Error bookkeeping survives flush; a same-cycle set beats err_clr.
      if (push && (bus.cmd_time < last_q)) order_err_q <= 1'b1;
      else if (err_clr)                     order_err_q <= 1'b0;

      if (fire && late) begin
        if (err_clr)                 late_cnt_q <= 16'd1;
        else if (late_cnt_q != '1)   late_cnt_q <= late_cnt_q + 16'd1;
      end else if (err_clr) begin
        late_cnt_q <= '0;
      end

      if (flush) begin
        state_q     <= IDLE;
        wptr_q      <= '0;
        rptr_q      <= '0;
        cnt_q       <= '0;
        last_q      <= '0;
        evt_valid_q <= 1'b0;
      end else begin
        if (push) begin
          wptr_q <= wptr_q + AW'(1);
          last_q <= bus.cmd_time;
        end
        if (fire) rptr_q <= rptr_q + AW'(1);
        case ({push, fire})
          2'b10:   cnt_q <= cnt_q + PW'(1);
          2'b01:   cnt_q <= cnt_q - PW'(1);
          default: cnt_q <= cnt_q;
        endcase

        case (state_q)
          IDLE: if ((cnt_q != '0) && enable) state_q <= ARMED;
          ARMED: begin
            if (fire) begin
              state_q     <= HOLD;
              evt_valid_q <= 1'b1;
              evt_id_q    <= head.id;
              evt_time_q  <= counter;
              evt_late_q  <= late;
            end else if (!enable || (cnt_q == '0)) begin
              state_q <= IDLE;
            end
          end
          HOLD: begin
            if (bus.evt_ready) begin
              evt_valid_q <= 1'b0;
              state_q     <= ((cnt_q != '0) && enable) ? ARMED : IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready = rdy;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_id    = evt_id_q;
  assign bus.evt_time  = evt_time_q;
  assign bus.evt_late  = evt_late_q;
  assign pending       = cnt_q;
  assign order_err     = order_err_q;
  assign late_cnt      = late_cnt_q;
endmodule

// File: doc/caliptra_fpga_sync_sched.md
Name: caliptra_fpga_sync_sched

Overview:
Timed-event scheduler driven by the free-running 64-bit sync counter of the FPGA sync block. Software or host logic queues (time, id) commands. The block releases each event on a valid/ready output once the counter reaches the event's time. Downstream triggers use these events (e.g. reset release, stimulus injection) for cycle-deterministic co-simulation sequencing.

Parameters:
DEPTH, 8, command queue depth in entries; power of two, 2..64.
ID_W, 8, event identifier width.
LATE_TOL, 0, cycles past the scheduled time still considered on time.

Ports:
aclk  in  1  clock; all logic on rising edge.
rstn  in  1  reset; asynchronous assert, active-low.
counter  in  64  free-running sync counter value, same clock domain.
enable  in  1  1 = events may fire; 0 = scheduling paused.
flush  in  1  synchronous clear of queue and held event.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_time  in  64  counter value at which the event fires.
cmd_id  in  ID_W  event identifier.
evt_valid  out  1  fired event present.
evt_ready  in  1  consumer accepts the event.
evt_id  out  ID_W  id of the fired event.
evt_time  out  64  counter value sampled at the fire decision.
evt_late  out  1  fired more than LATE_TOL cycles after cmd_time.
pending  out  $clog2(DEPTH+1)  queued entries, excluding the held event.
order_err  out  1  sticky; a command was accepted with time < previous accepted time.
late_cnt  out  16  saturating count of late events.
err_clr  in  1  clears order_err and late_cnt.

Behaviour:
- Reset (rstn low, async): queue empty, state IDLE, evt_valid/evt_id/evt_time/evt_late=0, order_err=0, late_cnt=0, last-accepted-time register=0. cmd_ready=1 immediately after rstn deasserts.
- cmd_ready = (pending < DEPTH) & ~flush, combinational. No bypass: a full queue stays not-ready even in a cycle that pops.
- Queue is FIFO in acceptance order; there is no sorting. An accepted cmd_time strictly less than the last accepted time sets order_err; the entry is still enqueued and fires in FIFO order. Equal times are legal.
- All time comparisons are unsigned 64-bit. Counter wrap at 2^64 is not supported.
- States:
  - IDLE: queue empty or enable=0. Go to ARMED when pending>0 & enable.
  - ARMED: compare head.time against counter each cycle. If counter >= head.time in cycle N: pop head, load the output register, go to HOLD. In cycle N+1: evt_valid=1, evt_time=counter(N), evt_late=(counter(N)-head.time > LATE_TOL). If enable falls, go to IDLE; the head is kept.
  - HOLD: outputs stable while evt_ready=0. On evt_valid & evt_ready: evt_valid=0 next cycle; go to ARMED if pending>0 & enable, else IDLE.
- Back-to-back: after a handshake in cycle M, the next evt_valid is no earlier than cycle M+2. An already-due head fires then with evt_late set as computed.
- enable=0 blocks new fires only. A held event stays valid until accepted.
- late_cnt increments by 1 at each fire with evt_late=1, saturating at 0xFFFF.
- err_clr:
  - clears order_err and late_cnt.
  - A same-cycle set takes priority over clear: order_err=1, late_cnt=1.
- flush (synchronous, highest priority): next cycle pending=0, evt_valid=0, state IDLE, last-accepted-time=0. order_err and late_cnt are unaffected. A command presented during flush is not accepted.
- pending updates the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- No combinational path from cmd_* or evt_ready to evt_*.

Test Plan:
- Reset, enable=1, counter=100. Push (time=105,id=3). -> evt_valid first high the cycle after counter=105; evt_id=3, evt_time=105, evt_late=0, pending 1->0.
- Push times 10,20,30 while counter=50, LATE_TOL=0, evt_ready=1. -> three events id order preserved, evt_valid spaced 2 cycles apart, all evt_late=1, late_cnt=3.
- Fill DEPTH=8 with enable=0. -> cmd_ready=0 at pending=8; a 9th command is not accepted. Set enable=1 with all due -> drains 8 events, then cmd_ready=1.
- Push time=200 then time=150. -> order_err=1 after the second accept. Both fire in push order (ids preserved). Pulse err_clr -> order_err=0.
- Hold evt_ready=0 with an event in HOLD, then assert flush for 1 cycle with 3 queued. -> next cycle evt_valid=0, pending=0, late_cnt unchanged.
- Assert rstn low mid-HOLD for 1 cycle (async). -> evt_valid=0 immediately, pending=0. After release, a push of time=counter+2 fires normally.
